// File: rtl/link_status_monitor.sv
// -----------------------------------------------------------------------------
// link_status_monitor
//
// Cleans up the raw per-port link bits coming out of the MDIO status poller and
// turns them into the signals the rest of the board cares about: a debounced
// link level, single-cycle up/down events, a saturating per-port link-flap
// counter, a maskable sticky interrupt and a per-port status LED drive.
//
// Each port runs its own four-state debounce machine (DOWN, UP_PEND, UP,
// DOWN_PEND). A new synchronized level must be seen on DEB_CYCLES+1
// consecutive clocks (one entry clock plus DEB_CYCLES counted clocks) before
// it is accepted; any return to the old level abandons the pending change
// silently and the next attempt restarts its count from zero.
//
// Ports
//   clk          system clock (same domain as the MDIO block)
//   reset        asynchronous, active-low reset; clears every flop
//   port_link    raw link status per port, 1 = up, asynchronous to clk
//   link_stable  debounced link level per port
//   link_up_evt  one-cycle pulse coincident with link_stable rising
//   link_dn_evt  one-cycle pulse coincident with link_stable falling
//   irq_mask     1 = port does not contribute to irq
//   irq_ack      one-cycle pulse clearing all pending irq_src bits
//   irq_src      sticky per-port pending-event bits (not masked)
//   irq          registered OR of irq_src & ~irq_mask
//   flap_sel     port index for the flap counter read port
//   flap_cnt     selected port's link-down count (0 when flap_sel >= NPORT)
//   flap_clr     clears every flap counter; wins over a same-cycle increment
//   led          per-port LED: on when UP, off when DOWN, blinking while pending
// -----------------------------------------------------------------------------
module link_status_monitor #(
    parameter int NPORT      = 4,
    parameter int DEB_CYCLES = 1000,
    parameter int CNT_W      = 8,
    parameter int BLINK_W    = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NPORT-1:0]   port_link,
    output logic [NPORT-1:0]   link_stable,
    output logic [NPORT-1:0]   link_up_evt,
    output logic [NPORT-1:0]   link_dn_evt,
    input  logic [NPORT-1:0]   irq_mask,
    input  logic               irq_ack,
    output logic [NPORT-1:0]   irq_src,
    output logic               irq,
    input  logic [1:0]         flap_sel,
    output logic [CNT_W-1:0]   flap_cnt,
    input  logic               flap_clr,
    output logic [NPORT-1:0]   led
);

    localparam int             DW       = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0]  DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        DOWN      = 2'd0,
        UP_PEND   = 2'd1,
        UP        = 2'd2,
        DOWN_PEND = 2'd3
    } link_state_t;

    // Saturating increment for the flap counters: holds at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic [NPORT-1:0]   sync_p0;
    logic [NPORT-1:0]   sync_p1;

    link_state_t        state_q [NPORT];
    link_state_t        state_d [NPORT];
    logic [DW-1:0]      deb_q   [NPORT];
    logic [DW-1:0]      deb_d   [NPORT];
    logic [NPORT-1:0]   up_d;
    logic [NPORT-1:0]   dn_d;

    logic [CNT_W-1:0]   flap_q  [NPORT];
    logic [BLINK_W-1:0] blink_div;
    logic               blink_phase;

    assign blink_phase = blink_div[BLINK_W-1];

    // ---- stage p0/p1: two-flop synchronizer on the raw link bits ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= port_link;
            sync_p1 <= sync_p0;
        end
    end

    // ---- debounce FSM: state, count and event registers ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NPORT; i++) begin
                state_q[i] <= DOWN;
                deb_q[i]   <= '0;
            end
            link_up_evt <= '0;
            link_dn_evt <= '0;
        end else begin
            for (int i = 0; i < NPORT; i++) begin
                state_q[i] <= state_d[i];
                deb_q[i]   <= deb_d[i];
            end
            link_up_evt <= up_d;
            link_dn_evt <= dn_d;
        end
    end

    // Next state, event detection and per-port level/LED decode. The event
    // pulses are registered from up_d/dn_d, so they land on the same edge that
    // moves the state into UP/DOWN and therefore coincide with link_stable.
    always_comb begin
        up_d        = '0;
        dn_d        = '0;
        link_stable = '0;
        led         = '0;
        for (int i = 0; i < NPORT; i++) begin
            state_d[i] = state_q[i];
            deb_d[i]   = deb_q[i];

            unique case (state_q[i])
                DOWN: begin
                    if (sync_p1[i]) begin
                        state_d[i] = UP_PEND;
                        deb_d[i]   = '0;
                    end
                end
                UP_PEND: begin
                    if (!sync_p1[i]) begin
                        state_d[i] = DOWN;
                    end else if (deb_q[i] == DEB_LAST) begin
                        state_d[i] = UP;
                        up_d[i]    = 1'b1;
                    end else begin
                        deb_d[i] = deb_q[i] + DW'(1);
                    end
                end
                UP: begin
                    if (!sync_p1[i]) begin
                        state_d[i] = DOWN_PEND;
                        deb_d[i]   = '0;
                    end
                end
                DOWN_PEND: begin
                    if (sync_p1[i]) begin
                        state_d[i] = UP;
                    end else if (deb_q[i] == DEB_LAST) begin
                        state_d[i] = DOWN;
                        dn_d[i]    = 1'b1;
                    end else begin
                        deb_d[i] = deb_q[i] + DW'(1);
                    end
                end
                default: begin
                    state_d[i] = DOWN;
                    deb_d[i]   = '0;
                end
            endcase

            // The accepted level only changes on leaving a PEND state, so
            // DOWN_PEND still reports "up" and UP_PEND still reports "down".
            link_stable[i] = (state_q[i] == UP) || (state_q[i] == DOWN_PEND);

            case (state_q[i])
                UP:      led[i] = 1'b1;
                DOWN:    led[i] = 1'b0;
                default: led[i] = blink_phase;
            endcase
        end
    end

    // ---- flap counters: bump on the debounced falling edge ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NPORT; i++) begin
                flap_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NPORT; i++) begin
                if (flap_clr) begin
                    flap_q[i] <= '0;
                end else if (dn_d[i]) begin
                    flap_q[i] <= sat_inc(flap_q[i]);
                end
            end
        end
    end

    // Read port; indices with no counter behind them read as zero.
    always_comb begin
        flap_cnt = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (int'(flap_sel) == i) begin
                flap_cnt = flap_q[i];
            end
        end
    end

    // ---- interrupt: sticky pending bits, then registered masked OR ----
    // irq_src reacts to the registered event pulses, so an irq_ack seen in
    // the same cycle as an event clears the older bits while the new one lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_src <= '0;
            irq     <= 1'b0;
        end else begin
            irq_src <= (irq_src & ~{NPORT{irq_ack}}) | link_up_evt | link_dn_evt;
            irq     <= |(irq_src & ~irq_mask);
        end
    end

    // ---- LED blink divider: free-running, MSB is the blink phase ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_div <= '0;
        end else begin
            blink_div <= blink_div + BLINK_W'(1);
        end
    end

endmodule
